// File: rtl/arbitro_tx_32.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// arbitro_tx_32
//
// Round-robin arbiter and sequencer that shares a single 32-bit UART word
// transmitter among N_REQ requesters (PC dump, register dump, memory dump,
// status, ...). One requester holds the grant at a time. Its words go out
// one by one, and each word is paced against the transmitter's ready line.
// A grant lasts until the requester flags its last word, stops presenting
// words, or reaches MAX_BURST words. Any of these releases the grant.
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset      asynchronous reset, active low
//   i_req_valid  per-requester word valid, held until accepted
//   i_req_last   per-requester end-of-burst flag, sampled with the word
//   i_req_data   requester k's word at [k*NB_DATA +: NB_DATA]
//   o_req_ready  per-requester accept (combinational, only for the grantee)
//   o_grant      registered one-hot grant, zero when idle
//   o_tx_data    word presented to the transmitter
//   o_tx_valid   one-cycle start pulse to the transmitter
//   i_tx_ready   transmitter idle; drops after accepting, rises when done
//   o_busy       high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module arbitro_tx_32 #(
    parameter int NB_DATA   = 32,
    parameter int N_REQ     = 4,
    parameter int NB_SEL    = 2,
    parameter int MAX_BURST = 16,
    parameter int NB_BURST  = 5
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ-1:0]         i_req_last,
    input  logic [N_REQ*NB_DATA-1:0] i_req_data,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic [N_REQ-1:0]         o_grant,
    output logic [NB_DATA-1:0]       o_tx_data,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,
    output logic                     o_busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [NB_BURST-1:0] BURST_LIMIT = NB_BURST'(MAX_BURST);
    localparam logic [NB_SEL-1:0]   LAST_SEL    = NB_SEL'(N_REQ - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t               state_reg;
    logic [N_REQ-1:0]     grant_reg;
    logic [NB_SEL-1:0]    sel_reg;          // index of the current grantee
    logic [NB_SEL-1:0]    ptr_reg;          // round-robin search start
    logic [NB_BURST-1:0]  burst_reg;        // words sent in this grant
    logic                 last_reg;         // last flag of the word in flight
    logic [NB_DATA-1:0]   tx_data_reg;
    logic                 tx_valid_reg;
    logic [1:0]           ack_cnt_reg;      // cycles spent in WAIT_ACK with ready high
    logic                 repulse_done_reg; // the single retry for this word is spent

    // -------------------------------------------------------------------------
    // Per-requester views of the flat data bus
    // -------------------------------------------------------------------------
    logic [NB_DATA-1:0] req_word [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign req_word[gi] = i_req_data[gi*NB_DATA +: NB_DATA];
        end
    endgenerate

    logic [NB_DATA-1:0] sel_word;
    logic               sel_valid;
    logic               sel_last;
    logic [NB_SEL-1:0]  sel_inc;

    assign sel_word  = req_word[sel_reg];
    assign sel_valid = i_req_valid[sel_reg];
    assign sel_last  = i_req_last[sel_reg];
    assign sel_inc   = (sel_reg == LAST_SEL) ? '0 : sel_reg + NB_SEL'(1);

    // -------------------------------------------------------------------------
    // Round-robin pick: first asserted valid at ptr, ptr+1, ... (mod N_REQ).
    // The loop walks offsets from the far end back to zero so that the
    // smallest offset with a request is the one left standing.
    // -------------------------------------------------------------------------
    logic               pick_found;
    logic [NB_SEL-1:0]  pick_idx;
    logic [NB_SEL-1:0]  cand_idx;
    logic [N_REQ-1:0]   pick_onehot;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_reg;
        cand_idx   = ptr_reg;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand_idx = NB_SEL'((int'(ptr_reg) + i) % N_REQ);
            if (i_req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign pick_onehot[gi] = (pick_idx == NB_SEL'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg        <= IDLE;
            grant_reg        <= '0;
            sel_reg          <= '0;
            ptr_reg          <= '0;
            burst_reg        <= '0;
            last_reg         <= 1'b0;
            tx_data_reg      <= '0;
            tx_valid_reg     <= 1'b0;
            ack_cnt_reg      <= '0;
            repulse_done_reg <= 1'b0;
        end else begin
            // The start pulse is one cycle wide unless a state re-arms it.
            tx_valid_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        grant_reg <= pick_onehot;
                        sel_reg   <= pick_idx;
                        burst_reg <= '0;
                        state_reg <= SEND;
                    end
                end

                SEND: begin
                    if (!sel_valid) begin
                        // Grantee has nothing more to send: end the burst
                        // quietly and hand the turn to the next index.
                        grant_reg <= '0;
                        ptr_reg   <= sel_inc;
                        state_reg <= IDLE;
                    end else if (i_tx_ready) begin
                        tx_data_reg      <= sel_word;
                        tx_valid_reg     <= 1'b1;
                        last_reg         <= sel_last;
                        if (burst_reg != BURST_LIMIT) begin
                            burst_reg <= burst_reg + NB_BURST'(1);
                        end
                        ack_cnt_reg      <= '0;
                        repulse_done_reg <= 1'b0;
                        state_reg        <= WAIT_ACK;
                    end
                    // valid with transmitter not ready: stall in place
                end

                WAIT_ACK: begin
                    if (!i_tx_ready) begin
                        state_reg <= WAIT_DONE;
                    end else begin
                        if (ack_cnt_reg != 2'd2) begin
                            ack_cnt_reg <= ack_cnt_reg + 2'd1;
                        end
                        // Ready still high at the end of the second cycle:
                        // the transmitter missed the pulse, so repeat it once
                        // with the data already held in tx_data_reg.
                        if (ack_cnt_reg == 2'd1 && !repulse_done_reg) begin
                            tx_valid_reg     <= 1'b1;
                            repulse_done_reg <= 1'b1;
                        end
                    end
                end

                WAIT_DONE: begin
                    if (i_tx_ready) begin
                        if (last_reg || burst_reg == BURST_LIMIT) begin
                            grant_reg <= '0;
                            ptr_reg   <= sel_inc;
                            state_reg <= IDLE;
                        end else begin
                            state_reg <= SEND;
                        end
                    end
                end

                default: begin
                    grant_reg <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Only the grantee sees ready, and only while SEND can take a word.
    always_comb begin
        o_req_ready = '0;
        if (state_reg == SEND) begin
            o_req_ready = grant_reg & {N_REQ{i_tx_ready}};
        end
    end

    assign o_grant    = grant_reg;
    assign o_tx_data  = tx_data_reg;
    assign o_tx_valid = tx_valid_reg;
    assign o_busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_arbitro_tx_32.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_arbitro_tx_32
//
// Requesters are word queues and the transmitter is a small reactive model;
// both are updated from one tick task just after each rising edge.
// Every o_tx_valid pulse is logged as {grant index, data} and compared
// against an expected log built from table constants, hand sequences, or a
// queue-level round-robin reference model for randomized rounds.
// -----------------------------------------------------------------------------
module tb_arbitro_tx_32;

    localparam int NB_DATA   = 32;
    localparam int N_REQ     = 4;
    localparam int MAX_BURST = 16;
    localparam int QDEPTH    = 256;

    logic                     i_clk = 1'b0;
    logic                     i_reset;
    logic [N_REQ-1:0]         i_req_valid;
    logic [N_REQ-1:0]         i_req_last;
    logic [N_REQ*NB_DATA-1:0] i_req_data;
    logic [N_REQ-1:0]         o_req_ready;
    logic [N_REQ-1:0]         o_grant;
    logic [NB_DATA-1:0]       o_tx_data;
    logic                     o_tx_valid;
    logic                     i_tx_ready;
    logic                     o_busy;

    always #5 i_clk = ~i_clk;

    arbitro_tx_32 #(
        .NB_DATA(32), .N_REQ(4), .NB_SEL(2), .MAX_BURST(16), .NB_BURST(5)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req_valid (i_req_valid),
        .i_req_last  (i_req_last),
        .i_req_data  (i_req_data),
        .o_req_ready (o_req_ready),
        .o_grant     (o_grant),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_busy      (o_busy)
    );

    int checks = 0;
    int errors = 0;

    // requester queues: bit 32 = last flag
    logic [32:0] rbuf [N_REQ][QDEPTH];
    int          rd   [N_REQ];
    int          wr   [N_REQ];

    // pulse logs: {grant index, data}
    logic [33:0] obs_q [$];
    logic [33:0] exp_q [$];

    // transmitter model
    int   busy_cnt;
    int   tx_busy_len;
    bit   tx_hold;
    bit   ignore_next;

    logic [N_REQ-1:0] prev_grant = '0;
    int               m_ptr;

    typedef struct packed {
        logic [3:0]      mask;
        logic [2:0]      n;
        logic [3:0][1:0] order;
    } tvec_t;

    tvec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [N_REQ-1:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 0; k < N_REQ; k++) begin
            if (g[k]) r = 2'(k);
        end
        return r;
    endfunction

    function automatic bit pending();
        bit p;
        p = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (rd[k] < wr[k]) p = 1'b1;
        end
        return p;
    endfunction

    task automatic drive_reqs();
        for (int k = 0; k < N_REQ; k++) begin
            if (rd[k] < wr[k]) begin
                i_req_valid[k]                 = 1'b1;
                i_req_last[k]                  = rbuf[k][rd[k]][32];
                i_req_data[k*NB_DATA +: NB_DATA] = rbuf[k][rd[k]][31:0];
            end else begin
                i_req_valid[k]                 = 1'b0;
                i_req_last[k]                  = 1'b0;
                i_req_data[k*NB_DATA +: NB_DATA] = '0;
            end
        end
    endtask

    task automatic push_word(input int k, input logic last, input logic [31:0] d);
        if (rd[k] == wr[k]) begin
            rd[k] = 0;
            wr[k] = 0;
        end
        if (wr[k] < QDEPTH) begin
            rbuf[k][wr[k]] = {last, d};
            wr[k]++;
        end
    endtask

    task automatic tick();
        logic [N_REQ-1:0]   xfer;
        logic               pulse;
        logic [NB_DATA-1:0] pdata;
        logic [N_REQ-1:0]   pgrant;
        @(posedge i_clk);
        xfer   = i_req_valid & o_req_ready;
        pulse  = o_tx_valid;
        pdata  = o_tx_data;
        pgrant = o_grant;
        checks++;
        if ($countones(pgrant) > 1) begin
            errors++;
            $display("FAIL grant_onehot: got %b, required at most one bit set", pgrant);
        end
        if (pgrant != prev_grant) begin
            checks++;
            if (prev_grant != '0 && pgrant != '0) begin
                errors++;
                $display("FAIL grant_gap: got %b -> %b, required an idle cycle between grants", prev_grant, pgrant);
            end
            prev_grant = pgrant;
        end
        #1;
        for (int k = 0; k < N_REQ; k++) begin
            if (xfer[k]) rd[k]++;
        end
        if (pulse) obs_q.push_back({idx_of(pgrant), pdata});
        if (pulse && i_tx_ready) begin
            if (ignore_next) ignore_next = 1'b0;
            else             busy_cnt    = tx_busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        i_tx_ready = (busy_cnt == 0) && !tx_hold;
        drive_reqs();
        #1;
    endtask

    task automatic run_until_idle(input string name);
        int cyc;
        cyc = 0;
        while ((o_busy || pending()) && cyc < 5000) begin
            tick();
            cyc++;
        end
        chk({name, "_done"}, {62'd0, o_busy, pending()}, 64'd0);
    endtask

    task automatic compare_logs(input string name);
        int n;
        chk({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_word%0d", name, i), 64'(obs_q[i]), 64'(exp_q[i]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic apply_reset();
        i_reset = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            rd[k] = 0;
            wr[k] = 0;
        end
        tx_hold     = 1'b0;
        ignore_next = 1'b0;
        busy_cnt    = 0;
        tx_busy_len = 3;
        i_tx_ready  = 1'b1;
        drive_reqs();
        tick();
        tick();
        obs_q.delete();
        exp_q.delete();
        i_reset = 1'b1;
    endtask

    // Round-robin reference at queue level: pick the first non-empty
    // requester from the pointer, take words until a last flag, the burst
    // limit, or an empty queue, then move the pointer past the grantee.
    task automatic ref_model();
        int crd [N_REQ];
        int g;
        int n;
        bit done;
        logic [32:0] w;
        for (int k = 0; k < N_REQ; k++) crd[k] = rd[k];
        forever begin
            g = -1;
            for (int o = 0; o < N_REQ; o++) begin
                int c;
                c = (m_ptr + o) % N_REQ;
                if (g < 0 && crd[c] < wr[c]) g = c;
            end
            if (g < 0) break;
            n    = 0;
            done = 1'b0;
            while (!done) begin
                w = rbuf[g][crd[g]];
                crd[g]++;
                n++;
                exp_q.push_back({2'(g), w[31:0]});
                if (w[32] || n == MAX_BURST || crd[g] == wr[g]) done = 1'b1;
            end
            m_ptr = (g + 1) % N_REQ;
        end
    endtask

    function automatic logic [31:0] tdat(input int r, input int k);
        return 32'hA000_0000 + 32'(r * 256 + k);
    endfunction

    initial begin
        logic [31:0] wa;
        logic [31:0] wb;
        bit          seen;

        tbl[0] = '{4'b1111, 3'd4, {2'd3, 2'd2, 2'd1, 2'd0}};
        tbl[1] = '{4'b1111, 3'd4, {2'd3, 2'd2, 2'd1, 2'd0}};
        tbl[2] = '{4'b0001, 3'd1, {2'd0, 2'd0, 2'd0, 2'd0}};
        tbl[3] = '{4'b1111, 3'd4, {2'd0, 2'd3, 2'd2, 2'd1}};
        tbl[4] = '{4'b0101, 3'd2, {2'd0, 2'd0, 2'd0, 2'd2}};
        tbl[5] = '{4'b1000, 3'd1, {2'd0, 2'd0, 2'd0, 2'd3}};
        tbl[6] = '{4'b1010, 3'd2, {2'd0, 2'd0, 2'd3, 2'd1}};
        tbl[7] = '{4'b0110, 3'd2, {2'd0, 2'd0, 2'd2, 2'd1}};
        tbl[8] = '{4'b1001, 3'd2, {2'd0, 2'd0, 2'd0, 2'd3}};

        // ---- reset state, with a request already pending ----
        i_reset     = 1'b0;
        tx_hold     = 1'b0;
        ignore_next = 1'b0;
        busy_cnt    = 0;
        tx_busy_len = 3;
        i_tx_ready  = 1'b1;
        for (int k = 0; k < N_REQ; k++) begin
            rd[k] = 0;
            wr[k] = 0;
        end
        push_word(0, 1'b1, 32'h1234_5678);
        drive_reqs();
        tick();
        tick();
        chk("rst_grant",   64'(o_grant),     64'd0);
        chk("rst_txvalid", 64'(o_tx_valid),  64'd0);
        chk("rst_txdata",  64'(o_tx_data),   64'd0);
        chk("rst_ready",   64'(o_req_ready), 64'd0);
        chk("rst_busy",    64'(o_busy),      64'd0);
        chk("rst_nopulse", 64'(obs_q.size()), 64'd0);

        // ---- single word ----
        apply_reset();
        push_word(0, 1'b1, 32'hDEAD_BEEF);
        drive_reqs();
        tick();
        chk("single_grant", 64'(o_grant),     64'h1);
        chk("single_busy",  64'(o_busy),      64'd1);
        chk("single_ready", 64'(o_req_ready), 64'h1);
        tick();
        chk("single_pulse", 64'(o_tx_valid),  64'd1);
        chk("single_data",  64'(o_tx_data),   64'hDEAD_BEEF);
        chk("single_ready_off", 64'(o_req_ready), 64'd0);
        tick();
        chk("single_pulse_end", 64'(o_tx_valid), 64'd0);
        run_until_idle("single");
        chk("single_release", 64'(o_grant), 64'd0);
        chk("single_idle",    64'(o_busy),  64'd0);
        exp_q.push_back({2'd0, 32'hDEAD_BEEF});
        compare_logs("single");

        // ---- table: one word per requester in the mask, order from ptr ----
        apply_reset();
        for (int r = 0; r < 9; r++) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (tbl[r].mask[k]) push_word(k, 1'b1, tdat(r, k));
            end
            for (int j = 0; j < int'(tbl[r].n); j++) begin
                exp_q.push_back({tbl[r].order[j], tdat(r, int'(tbl[r].order[j]))});
            end
            drive_reqs();
            run_until_idle($sformatf("tbl%0d", r));
            compare_logs($sformatf("tbl%0d", r));
        end

        // ---- burst: req1 three words while req2 waits ----
        apply_reset();
        push_word(1, 1'b0, 32'h1111_1111);
        push_word(1, 1'b0, 32'h2222_2222);
        push_word(1, 1'b1, 32'h3333_3333);
        push_word(2, 1'b1, 32'h2A2A_2A2A);
        drive_reqs();
        exp_q.push_back({2'd1, 32'h1111_1111});
        exp_q.push_back({2'd1, 32'h2222_2222});
        exp_q.push_back({2'd1, 32'h3333_3333});
        exp_q.push_back({2'd2, 32'h2A2A_2A2A});
        run_until_idle("burst");
        compare_logs("burst");

        // ---- starvation limit: req0 streams 20 words, req3 waits ----
        apply_reset();
        for (int i = 0; i < 20; i++) push_word(0, 1'b0, 32'h5000_0000 + 32'(i));
        push_word(3, 1'b1, 32'h3333_AAAA);
        drive_reqs();
        for (int i = 0; i < 16; i++) exp_q.push_back({2'd0, 32'h5000_0000 + 32'(i)});
        exp_q.push_back({2'd3, 32'h3333_AAAA});
        for (int i = 16; i < 20; i++) exp_q.push_back({2'd0, 32'h5000_0000 + 32'(i)});
        run_until_idle("starve");
        compare_logs("starve");

        // ---- stall: transmitter not ready for 10 cycles in SEND ----
        apply_reset();
        tx_hold    = 1'b1;
        i_tx_ready = 1'b0;
        push_word(0, 1'b1, 32'h57A1_1000);
        drive_reqs();
        tick();
        chk("stall_grant", 64'(o_grant), 64'h1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("stall_valid%0d", i), 64'(o_tx_valid),  64'd0);
            chk($sformatf("stall_ready%0d", i), 64'(o_req_ready), 64'd0);
            chk($sformatf("stall_data%0d", i),  64'(o_tx_data),   64'd0);
        end
        tx_hold    = 1'b0;
        i_tx_ready = 1'b1;
        tick();
        chk("stall_pulse", 64'(o_tx_valid), 64'd1);
        chk("stall_data",  64'(o_tx_data),  64'h57A1_1000);
        run_until_idle("stall");
        exp_q.push_back({2'd0, 32'h57A1_1000});
        compare_logs("stall");

        // ---- missed pulse: transmitter ignores the first start pulse ----
        apply_reset();
        ignore_next = 1'b1;
        push_word(2, 1'b1, 32'hC0FF_EE00);
        drive_reqs();
        exp_q.push_back({2'd2, 32'hC0FF_EE00});
        exp_q.push_back({2'd2, 32'hC0FF_EE00});
        run_until_idle("repulse");
        compare_logs("repulse");

        // ---- reset in WAIT_DONE ----
        apply_reset();
        tx_busy_len = 4;
        push_word(0, 1'b1, 32'h0000_0A0A);
        drive_reqs();
        exp_q.push_back({2'd0, 32'h0000_0A0A});
        run_until_idle("rstmid_pre");
        compare_logs("rstmid_pre");
        push_word(1, 1'b1, 32'h0000_1B1B);
        drive_reqs();
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (obs_q.size() > 0) seen = 1'b1;
        end
        chk("rstmid_pulse_seen", 64'(seen), 64'd1);
        tick();
        i_reset = 1'b0;
        #1;
        chk("rstmid_grant",   64'(o_grant),     64'd0);
        chk("rstmid_txvalid", 64'(o_tx_valid),  64'd0);
        chk("rstmid_busy",    64'(o_busy),      64'd0);
        chk("rstmid_ready",   64'(o_req_ready), 64'd0);
        obs_q.delete();
        tick();
        tick();
        i_reset = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("rstmid_nopulse", 64'(obs_q.size()), 64'd0);
        wa = 32'h0000_C0C0;
        wb = 32'h0000_D1D1;
        push_word(0, 1'b1, wa);
        push_word(1, 1'b1, wb);
        drive_reqs();
        exp_q.push_back({2'd0, wa});
        exp_q.push_back({2'd1, wb});
        run_until_idle("rstmid_post");
        compare_logs("rstmid_post");

        // ---- randomized rounds against the reference model ----
        apply_reset();
        m_ptr = 0;
        for (int rnd = 0; rnd < 10; rnd++) begin
            tx_busy_len = int'($urandom_range(1, 4));
            for (int k = 0; k < N_REQ; k++) begin
                int nb;
                nb = int'($urandom_range(0, 2));
                for (int b = 0; b < nb; b++) begin
                    int len;
                    len = int'($urandom_range(1, 20));
                    for (int i = 0; i < len; i++) push_word(k, (i == len - 1), $urandom);
                end
            end
            if (!pending()) push_word(int'($urandom_range(0, 3)), 1'b1, $urandom);
            drive_reqs();
            ref_model();
            run_until_idle($sformatf("rand%0d", rnd));
            compare_logs($sformatf("rand%0d", rnd));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
